prom_arbiter: RTL and testbench

PROM_ARBITER -- requirements
Module: prom_arbiter

---
 rtl/prom_arbiter.sv | 105 ++++++++++
 tb/tb_prom_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/prom_arbiter.sv
// prom_arbiter: two-requester PROM read arbiter with address/OE/turnaround dwell timing.
// Define PROM_ARB_RR_EN for round-robin on simultaneous requests (default: requester 0 wins).
module prom_arbiter #(
  parameter int ADDR_CYC = 2,
  parameter int OE_CYC   = 2,
  parameter int TURN_CYC = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [15:0] prom_addr,
  output logic        prom_oen,
  input  logic [15:0] prom_dout
);
  typedef enum logic [1:0] {IDLE, ADDR, OE, TURN} state_t;
  localparam logic [3:0] A_LD = 4'(ADDR_CYC - 1);
  localparam logic [3:0] O_LD = 4'(OE_CYC - 1);
  localparam logic [3:0] T_LD = 4'(TURN_CYC - 1);
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, rdata_q, rdata_d;
  logic        gnt_q, gnt_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic        pick1, last;
`ifdef PROM_ARB_RR_EN
  logic        ptr_q, ptr_d;
  assign pick1 = req1 & (~req0 | ptr_q);
`else
  assign pick1 = req1 & ~req0;
`endif
  assign last      = cnt_q == 4'd0;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign rdata     = rdata_q;
  assign prom_addr = addr_q;
  assign busy      = state_q != IDLE;
  assign prom_oen  = state_q != OE;
  always_comb begin
    state_d = state_q;
    cnt_d   = last ? 4'd0 : cnt_q - 4'd1;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    gnt_d   = gnt_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
`ifdef PROM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      IDLE: if (req0 | req1) begin
        state_d = ADDR;
        cnt_d   = A_LD;
        addr_d  = pick1 ? addr1 : addr0;
        gnt_d   = pick1;
`ifdef PROM_ARB_RR_EN
        ptr_d   = ~pick1;
`endif
      end
      ADDR: if (last) begin
        state_d = OE;
        cnt_d   = O_LD;
      end
      OE: if (last) begin
        state_d = TURN;
        cnt_d   = T_LD;
        rdata_d = prom_dout;
        ack0_d  = ~gnt_q;
        ack1_d  = gnt_q;
      end
      TURN: if (last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'd0;
      rdata_q <= 16'd0;
      gnt_q   <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
`ifdef PROM_ARB_RR_EN
      ptr_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      gnt_q   <= gnt_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
`ifdef PROM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end
endmodule

// File: tb/tb_prom_arbiter.sv
// tb_prom_arbiter: directed checks of prom_arbiter timing, arbitration, stability and reset.
module tb_prom_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0 = 0, req1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0;
  logic ack0, ack1, busy, prom_oen;
  logic [15:0] rdata, prom_addr, prom_dout;
  logic b_req = 0, b_req1 = 0;
  logic [15:0] b_addr = 0, b_addr1 = 0;
  logic b_ack0, b_ack1, b_busy, b_oen;
  logic [15:0] b_rdata, b_paddr, b_dout;
  int checks = 0, failures = 0, ack1_cnt = 0, both_cnt = 0;

  function automatic logic [15:0] mem(input logic [15:0] a);
    case (a)
      16'h0000: return 16'hF000;
      16'h0001: return 16'hF101;
      16'h0002: return 16'hF210;
      16'h0003: return 16'hF311;
      16'h0005: return 16'hE1FE;
      default:  return a ^ 16'hA5A5;
    endcase
  endfunction

  assign prom_dout = prom_oen ? 16'hDEAD : mem(prom_addr);
  assign b_dout    = b_oen ? 16'hDEAD : mem(b_paddr);

  prom_arbiter dut (.clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .addr0(addr0), .addr1(addr1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .prom_addr(prom_addr), .prom_oen(prom_oen),
    .prom_dout(prom_dout));
  prom_arbiter #(.ADDR_CYC(3), .OE_CYC(1), .TURN_CYC(2)) dut2 (.clk(clk), .rst_n(rst_n), .req0(b_req),
    .req1(b_req1), .addr0(b_addr), .addr1(b_addr1), .ack0(b_ack0), .ack1(b_ack1), .rdata(b_rdata),
    .busy(b_busy), .prom_addr(b_paddr), .prom_oen(b_oen), .prom_dout(b_dout));

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ack1) ack1_cnt++;
    if ((ack0 && ack1) || (b_ack0 && b_ack1)) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts edges until the selected ack is seen; 17 means it never came
  task automatic ack_after(input string tag, input int sel, input int exp);
    int n;
    for (n = 1; n <= 16; n++) begin
      tick();
      if ((sel == 0 && ack0) || (sel == 1 && ack1) || (sel == 2 && b_ack0)) break;
    end
    chk(tag, n, exp);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    for (n = 0; n < 20 && busy; n++) tick();
    chk(tag, busy, 0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_oen", prom_oen, 1);
    chk("rst_addr", prom_addr, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_acks", {ack0, ack1}, 0);
    rst_n = 1;
    tick();
    // single read by requester 1
    req1 = 1; addr1 = 16'h0005;
    tick();
    chk("sr_busy", busy, 1);
    chk("sr_paddr", prom_addr, 16'h0005);
    chk("sr_oen_addr", prom_oen, 1);
    req1 = 0;
    tick();
    chk("sr_oen_addr2", prom_oen, 1);
    tick();
    chk("sr_oen_oe1", prom_oen, 0);
    tick();
    chk("sr_oen_oe2", prom_oen, 0);
    chk("sr_no_early_ack", ack1, 0);
    tick();
    chk("sr_ack1", {ack0, ack1}, 2'b01);
    chk("sr_rdata", rdata, 16'hE1FE);
    chk("sr_oen_turn", prom_oen, 1);
    chk("sr_busy_turn", busy, 1);
    tick();
    chk("sr_ack_pulse", ack1, 0);
    chk("sr_idle", busy, 0);
    chk("sr_rdata_hold", rdata, 16'hE1FE);
    // simultaneous requests, fixed priority
    ack1_cnt = 0;
    req0 = 1; addr0 = 16'h0000; req1 = 1; addr1 = 16'h0001;
    tick();
    chk("sim_grant_addr", prom_addr, 16'h0000);
    ack_after("sim_ack0_first", 0, 4);
    chk("sim_rdata", rdata, 16'hF000);
    ack_after("sim_ack0_spacing", 0, 6);
    req0 = 0; req1 = 0;
    chk("sim_no_ack1", ack1_cnt, 0);
    wait_idle("sim_idle");
    // address change during ADDR is ignored
    req0 = 1; addr0 = 16'h0002;
    tick();
    chk("as_paddr_grant", prom_addr, 16'h0002);
    addr0 = 16'h0003;
    tick();
    chk("as_paddr_held", prom_addr, 16'h0002);
    req0 = 0;
    ack_after("as_ack", 0, 3);
    chk("as_rdata", rdata, 16'hF210);
    chk("as_paddr_ack", prom_addr, 16'h0002);
    wait_idle("as_idle");
    // request dropped one cycle after grant
    req0 = 1; addr0 = 16'h0007;
    tick();
    tick();
    req0 = 0;
    ack_after("rd_ack", 0, 3);
    chk("rd_rdata", rdata, 16'hA5A2);
    tick();
    chk("rd_idle", busy, 0);
    // reset in the middle of OE
    ack1_cnt = 0;
    req1 = 1; addr1 = 16'h0005;
    tick();
    req1 = 0;
    tick(); tick();
    chk("ro_in_oe", prom_oen, 0);
    #2 rst_n = 0;
    #1;
    chk("ro_oen_async", prom_oen, 1);
    chk("ro_busy_async", busy, 0);
    chk("ro_addr_async", prom_addr, 0);
    tick(); tick(); tick();
    chk("ro_no_ack", ack1_cnt, 0);
    chk("ro_rdata", rdata, 0);
    req0 = 1; addr0 = 16'h0003; rst_n = 1;
    tick();
    chk("ro_regrant", {busy, prom_addr}, {1'b1, 16'h0003});
    req0 = 0;
    ack_after("ro_ack", 0, 4);
    chk("ro_rdata2", rdata, 16'hF311);
    wait_idle("ro_idle");
    // alternate timing parameters
    b_req = 1; b_addr = 16'h0001;
    tick();
    chk("p_grant", {b_busy, b_paddr}, {1'b1, 16'h0001});
    ack_after("p_ack", 2, 4);
    chk("p_rdata", b_rdata, 16'hF101);
    ack_after("p_spacing", 2, 7);
    b_req = 0;
    tick(); tick(); tick();
    chk("p_idle", b_busy, 0);
    chk("no_dual_ack", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
